// File: rtl/updown_pkg.sv
// Shared constants for the up/down modulo counter: 7-segment glyphs ({a,b,c,d,e,f,g},
// active-high) and the hex digit lookup used by hex_to_seg7.
package updown_pkg;

  localparam logic [6:0] SEG_U = 7'b0111110;
  localparam logic [6:0] SEG_D = 7'b0111101;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to 7-segment hex decoder ({a,b,c,d,e,f,g}, active-high).
module hex_to_seg7
  import updown_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_seg(nibble);
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with enable, clamped parallel load, wrap/saturate mode,
// registered terminal-count pulse and 7-segment direction/value glyphs.
module updown_mod_counter
  import updown_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic [6:0]       dir_seg,
  output logic [6:0]       val_seg,
  output logic             digit
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic [6:0]       dir_q, dir_d;
  logic             at_max, at_zero;
  logic [3:0]       nibble;

  // Boundaries are explicit compares so a non-power-of-2 modulus wraps correctly.
  assign at_max  = (count_q == MAX_C);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    dir_d   = dir_q;
    if (load) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (en) begin
      dir_d = ud ? SEG_U : SEG_D;
      if (ud) begin
        if (at_max) begin
          tc_d    = 1'b1;
          count_d = (SATURATE != 0) ? count_q : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          tc_d    = 1'b1;
          count_d = (SATURATE != 0) ? count_q : MAX_C;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      dir_q   <= SEG_U;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      dir_q   <= dir_d;
    end
  end

  generate
    if (WIDTH >= 4) begin : g_nib
      assign nibble = count_q[3:0];
    end else begin : g_ext
      assign nibble = {{(4-WIDTH){1'b0}}, count_q};
    end
  endgenerate

  hex_to_seg7 u_hex (
    .nibble (nibble),
    .seg    (val_seg)
  );

  assign count   = count_q;
  assign tc      = tc_q;
  assign dir_seg = dir_q;
  assign digit   = 1'b1;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: three instances (default wrap, modulus 10,
// saturating) share one stimulus stream; each scenario task checks the relevant instance.
module tb_updown_mod_counter;

  localparam logic [6:0] EXP_U = 7'b0111110;
  localparam logic [6:0] EXP_D = 7'b0111101;

  logic clk = 1'b0;
  logic rst, en, ud, load;
  logic [3:0] load_val;

  logic [3:0] a_count, b_count, c_count;
  logic       a_tc, b_tc, c_tc;
  logic [6:0] a_dir, b_dir, c_dir;
  logic [6:0] a_val, b_val, c_val;
  logic       a_digit, b_digit, c_digit;

  logic [6:0] seg_tab [16];
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .load_val(load_val),
    .count(a_count), .tc(a_tc), .dir_seg(a_dir), .val_seg(a_val), .digit(a_digit)
  );

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9)) dut_b (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .load_val(load_val),
    .count(b_count), .tc(b_tc), .dir_seg(b_dir), .val_seg(b_val), .digit(b_digit)
  );

  updown_mod_counter #(.WIDTH(4), .SATURATE(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .load_val(load_val),
    .count(c_count), .tc(c_tc), .dir_seg(c_dir), .val_seg(c_val), .digit(c_digit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; ud = 1'b1; load = 1'b0; load_val = 4'd0;
    tick();
    tick();
    total_cnt++;
    if (a_count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", a_count); else pass_cnt++;
    total_cnt++;
    if (a_tc !== 1'b0) $display("FAIL reset_tc got=%b exp=0", a_tc); else pass_cnt++;
    total_cnt++;
    if (a_dir !== EXP_U) $display("FAIL reset_dir got=%b exp=%b", a_dir, EXP_U); else pass_cnt++;
    total_cnt++;
    if (a_val !== 7'b1111110) $display("FAIL reset_val got=%b exp=1111110", a_val); else pass_cnt++;
    total_cnt++;
    if (a_digit !== 1'b1) $display("FAIL reset_digit got=%b exp=1", a_digit); else pass_cnt++;
    total_cnt++;
    if (b_count !== 4'd0 || c_count !== 4'd0)
      $display("FAIL reset_other got=%0d,%0d exp=0,0", b_count, c_count);
    else pass_cnt++;
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_c;
    rst = 1'b1; en = 1'b1; ud = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_c = 4'(i % 16);
      total_cnt++;
      if (a_count !== exp_c) $display("FAIL up_count step=%0d got=%0d exp=%0d", i, a_count, exp_c);
      else pass_cnt++;
      total_cnt++;
      if (a_tc !== (i == 16)) $display("FAIL up_tc step=%0d got=%b exp=%b", i, a_tc, (i == 16));
      else pass_cnt++;
      total_cnt++;
      if (a_val !== seg_tab[exp_c]) $display("FAIL up_val step=%0d got=%b exp=%b", i, a_val, seg_tab[exp_c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_down_mod9();
    logic [3:0] exp_c;
    logic       exp_tc;
    rst = 1'b0; en = 1'b0;
    tick();
    rst = 1'b1; en = 1'b1; ud = 1'b0;
    exp_c = 4'd0;
    for (int i = 1; i <= 21; i++) begin
      exp_tc = (exp_c == 4'd0);
      exp_c  = (exp_c == 4'd0) ? 4'd9 : exp_c - 4'd1;
      tick();
      total_cnt++;
      if (b_count !== exp_c) $display("FAIL down9_count step=%0d got=%0d exp=%0d", i, b_count, exp_c);
      else pass_cnt++;
      total_cnt++;
      if (b_tc !== exp_tc) $display("FAIL down9_tc step=%0d got=%b exp=%b", i, b_tc, exp_tc);
      else pass_cnt++;
      total_cnt++;
      if (b_dir !== EXP_D) $display("FAIL down9_dir step=%0d got=%b exp=%b", i, b_dir, EXP_D);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_cv [4];
    logic       exp_tv [4];
    exp_cv = '{4'd15, 4'd15, 4'd15, 4'd14};
    exp_tv = '{1'b0, 1'b1, 1'b1, 1'b0};
    load = 1'b1; en = 1'b0; load_val = 4'd14;
    tick();
    total_cnt++;
    if (c_count !== 4'd14) $display("FAIL sat_load got=%0d exp=14", c_count); else pass_cnt++;
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ud = (i < 3);
      tick();
      total_cnt++;
      if (c_count !== exp_cv[i]) $display("FAIL sat_count step=%0d got=%0d exp=%0d", i, c_count, exp_cv[i]);
      else pass_cnt++;
      total_cnt++;
      if (c_tc !== exp_tv[i]) $display("FAIL sat_tc step=%0d got=%b exp=%b", i, c_tc, exp_tv[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_load_priority();
    en = 1'b1; ud = 1'b1; load = 1'b0;
    tick();
    load = 1'b1; en = 1'b1; ud = 1'b0; load_val = 4'd12;
    tick();
    total_cnt++;
    if (b_count !== 4'd9) $display("FAIL load_clamp got=%0d exp=9", b_count); else pass_cnt++;
    total_cnt++;
    if (a_count !== 4'd12) $display("FAIL load_a got=%0d exp=12", a_count); else pass_cnt++;
    total_cnt++;
    if (b_dir !== EXP_U) $display("FAIL load_dir got=%b exp=%b", b_dir, EXP_U); else pass_cnt++;
    total_cnt++;
    if (a_tc !== 1'b0) $display("FAIL load_tc got=%b exp=0", a_tc); else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (b_count !== 4'd0 || a_count !== 4'd0)
      $display("FAIL rst_over_load got=%0d,%0d exp=0,0", b_count, a_count);
    else pass_cnt++;
    rst = 1'b1; load = 1'b0; en = 1'b1; ud = 1'b1;
    tick();
    total_cnt++;
    if (a_count !== 4'd1) $display("FAIL resume got=%0d exp=1", a_count); else pass_cnt++;
  endtask

  task automatic test_enable_hold();
    en = 1'b1; ud = 1'b0; load = 1'b0;
    tick();
    load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ud = i[0];
      tick();
      total_cnt++;
      if (a_count !== 4'd7 || b_count !== 4'd7)
        $display("FAIL hold_count step=%0d got=%0d,%0d exp=7,7", i, a_count, b_count);
      else pass_cnt++;
      total_cnt++;
      if (a_tc !== 1'b0) $display("FAIL hold_tc step=%0d got=%b exp=0", i, a_tc); else pass_cnt++;
      total_cnt++;
      if (a_dir !== EXP_D) $display("FAIL hold_dir step=%0d got=%b exp=%b", i, a_dir, EXP_D);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic       ud_v  [4];
    logic [3:0] exp_v [4];
    ud_v  = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_v = '{4'd8, 4'd7, 4'd6, 4'd7};
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ud = ud_v[i];
      tick();
      total_cnt++;
      if (a_count !== exp_v[i]) $display("FAIL b2b_count step=%0d got=%0d exp=%0d", i, a_count, exp_v[i]);
      else pass_cnt++;
      total_cnt++;
      if (a_dir !== (ud_v[i] ? EXP_U : EXP_D))
        $display("FAIL b2b_dir step=%0d got=%b exp=%b", i, a_dir, (ud_v[i] ? EXP_U : EXP_D));
      else pass_cnt++;
    end
  endtask

  initial begin
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    test_reset();
    test_up_wrap();
    test_down_mod9();
    test_saturate();
    test_load_priority();
    test_enable_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
